// File: rtl/fetch_stage_ctrl.sv
// Fetch stage: program counter, IF/ID pipeline register, hazard-control response,
// and debug statistics (saturating stall/flush counts, sticky stall-timeout flag).
module fetch_stage_ctrl #(
   parameter logic [31:0] RESET_PC  = 32'h0000_0000,
   parameter int unsigned MAX_STALL = 8,
   parameter int unsigned CNT_W     = 16
) (
   input  logic             Clk,
   input  logic             Rst,
   input  logic             PCWrite,
   input  logic             DecodeRegWrite,
   input  logic             flushControl,
   input  logic             BranchTaken,
   input  logic [31:0]      BranchTarget,
   input  logic             JumpTaken,
   input  logic [31:0]      JumpTarget,
   input  logic             CounterClear,
   input  logic [31:0]      InstrIn,
   output logic [31:0]      PCOut,
   output logic [31:0]      InstrOut,
   output logic [31:0]      PCPlus4Out,
   output logic             ValidOut,
   output logic [CNT_W-1:0] StallCount,
   output logic [CNT_W-1:0] FlushCount,
   output logic             StallTimeout
);

   typedef enum logic {RUN, HOLD} state_t;

   localparam logic [7:0]       MAX_RUN = 8'(MAX_STALL);
   localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

   state_t           state_q, state_d;
   logic [7:0]       run_q, run_d;
   logic [31:0]      pc_q, pc_d;
   logic [31:0]      instr_q, instr_d;
   logic [31:0]      pcp4_q, pcp4_d;
   logic             valid_q, valid_d;
   logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
   logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;
   logic             timeout_q, timeout_d;
   logic [31:0]      pc_plus4;

   assign pc_plus4 = pc_q + 32'd4;

   always_comb begin
      pc_d        = pc_q;
      instr_d     = instr_q;
      pcp4_d      = pcp4_q;
      valid_d     = valid_q;
      state_d     = state_q;
      run_d       = run_q;
      stall_cnt_d = stall_cnt_q;
      flush_cnt_d = flush_cnt_q;
      timeout_d   = timeout_q;

      // Redirects are only honoured when the PC is allowed to move; jump beats branch.
      if (PCWrite) begin
         if (JumpTaken)        pc_d = {JumpTarget[31:2], 2'b00};
         else if (BranchTaken) pc_d = {BranchTarget[31:2], 2'b00};
         else                  pc_d = pc_plus4;
      end

      if (flushControl) begin
         instr_d = 32'h0;
         pcp4_d  = 32'h0;
         valid_d = 1'b0;
      end else if (DecodeRegWrite) begin
         instr_d = InstrIn;
         pcp4_d  = pc_plus4;
         valid_d = 1'b1;
      end

      case (state_q)
         RUN: begin
            run_d = 8'd0;
            if (!PCWrite) begin
               state_d = HOLD;
               run_d   = 8'd1;
            end
         end
         HOLD: begin
            if (PCWrite) begin
               state_d = RUN;
               run_d   = 8'd0;
            end else if (run_q != 8'hFF) begin
               run_d = run_q + 8'd1;
            end
         end
         default: begin
            state_d = RUN;
            run_d   = 8'd0;
         end
      endcase

      if (run_d == MAX_RUN) timeout_d = 1'b1;

      if (!PCWrite && stall_cnt_q != CNT_MAX)    stall_cnt_d = stall_cnt_q + 1'b1;
      if (flushControl && flush_cnt_q != CNT_MAX) flush_cnt_d = flush_cnt_q + 1'b1;

      // Clear wins over any increment or timeout set in the same cycle.
      if (CounterClear) begin
         stall_cnt_d = '0;
         flush_cnt_d = '0;
         run_d       = 8'd0;
         timeout_d   = 1'b0;
      end
   end

   always_ff @(posedge Clk or negedge Rst) begin
      if (!Rst) begin
         state_q     <= RUN;
         run_q       <= 8'd0;
         pc_q        <= RESET_PC;
         instr_q     <= 32'h0;
         pcp4_q      <= 32'h0;
         valid_q     <= 1'b0;
         stall_cnt_q <= '0;
         flush_cnt_q <= '0;
         timeout_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         run_q       <= run_d;
         pc_q        <= pc_d;
         instr_q     <= instr_d;
         pcp4_q      <= pcp4_d;
         valid_q     <= valid_d;
         stall_cnt_q <= stall_cnt_d;
         flush_cnt_q <= flush_cnt_d;
         timeout_q   <= timeout_d;
      end
   end

   assign PCOut        = pc_q;
   assign InstrOut     = instr_q;
   assign PCPlus4Out   = pcp4_q;
   assign ValidOut     = valid_q;
   assign StallCount   = stall_cnt_q;
   assign FlushCount   = flush_cnt_q;
   assign StallTimeout = timeout_q;

endmodule

// File: tb/tb_fetch_stage_ctrl.sv
// Bench for fetch_stage_ctrl: directed scenarios then random traffic, all outputs
// compared every cycle against a behavioural model of the fetch stage.
module tb_fetch_stage_ctrl;

   localparam logic [31:0] RESET_PC  = 32'h0000_0000;
   localparam int          MAX_STALL = 4;
   localparam int          CNT_W     = 4;
   localparam int          CNT_MAXV  = (1 << CNT_W) - 1;

   logic             Clk = 1'b0;
   logic             Rst;
   logic             PCWrite, DecodeRegWrite, flushControl, BranchTaken, JumpTaken, CounterClear;
   logic [31:0]      BranchTarget, JumpTarget, InstrIn;
   logic [31:0]      PCOut, InstrOut, PCPlus4Out;
   logic             ValidOut, StallTimeout;
   logic [CNT_W-1:0] StallCount, FlushCount;

   int n_checks = 0;
   int n_fail   = 0;

   // Behavioural model state
   logic [31:0] m_pc, m_instr, m_pp4;
   logic        m_valid, m_to;
   int          m_stall, m_flush, m_run;

   fetch_stage_ctrl #(.RESET_PC(RESET_PC), .MAX_STALL(MAX_STALL), .CNT_W(CNT_W)) dut (
      .Clk(Clk), .Rst(Rst), .PCWrite(PCWrite), .DecodeRegWrite(DecodeRegWrite),
      .flushControl(flushControl), .BranchTaken(BranchTaken), .BranchTarget(BranchTarget),
      .JumpTaken(JumpTaken), .JumpTarget(JumpTarget), .CounterClear(CounterClear),
      .InstrIn(InstrIn), .PCOut(PCOut), .InstrOut(InstrOut), .PCPlus4Out(PCPlus4Out),
      .ValidOut(ValidOut), .StallCount(StallCount), .FlushCount(FlushCount),
      .StallTimeout(StallTimeout)
   );

   always #5 Clk = ~Clk;

   function automatic logic [31:0] mem(input logic [31:0] a);
      return {a[15:0], ~a[15:0]} ^ 32'h1234_0000;
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_pc = RESET_PC; m_instr = 0; m_pp4 = 0; m_valid = 0;
      m_stall = 0; m_flush = 0; m_run = 0; m_to = 0;
   endtask

   task automatic check_all(input string tag);
      check({tag, ".PCOut"},        PCOut,                m_pc);
      check({tag, ".InstrOut"},     InstrOut,             m_instr);
      check({tag, ".PCPlus4Out"},   PCPlus4Out,           m_pp4);
      check({tag, ".ValidOut"},     32'(ValidOut),        32'(m_valid));
      check({tag, ".StallCount"},   32'(StallCount),      32'(m_stall));
      check({tag, ".FlushCount"},   32'(FlushCount),      32'(m_flush));
      check({tag, ".StallTimeout"}, 32'(StallTimeout),    32'(m_to));
   endtask

   // Called just after a falling edge; applies one cycle of inputs and checks after the rising edge.
   task automatic step(input string tag, input logic pcw, input logic drw, input logic fl,
                       input logic br, input logic [31:0] bt, input logic jp,
                       input logic [31:0] jt, input logic clr);
      logic [31:0] fetched;
      PCWrite = pcw; DecodeRegWrite = drw; flushControl = fl; BranchTaken = br;
      BranchTarget = bt; JumpTaken = jp; JumpTarget = jt; CounterClear = clr;
      InstrIn = mem(PCOut);
      fetched = mem(m_pc);
      if (fl) begin
         m_instr = 0; m_pp4 = 0; m_valid = 0;
      end else if (drw) begin
         m_instr = fetched; m_pp4 = m_pc + 32'd4; m_valid = 1;
      end
      if (pcw) m_pc = jp ? (jt & ~32'h3) : br ? (bt & ~32'h3) : m_pc + 32'd4;
      m_run = pcw ? 0 : m_run + 1;
      if (m_run >= MAX_STALL) m_to = 1;
      if (!pcw && m_stall < CNT_MAXV) m_stall++;
      if (fl && m_flush < CNT_MAXV) m_flush++;
      if (clr) begin
         m_stall = 0; m_flush = 0; m_run = 0; m_to = 0;
      end
      @(posedge Clk);
      #1;
      check_all(tag);
      @(negedge Clk);
   endtask

   task automatic run_step(input string tag);
      step(tag, 1, 1, 0, 0, 0, 0, 0, 0);
   endtask

   task automatic stall_step(input string tag);
      step(tag, 0, 0, 0, 0, 0, 0, 0, 0);
   endtask

   initial begin
      Rst = 1'b0;
      PCWrite = 0; DecodeRegWrite = 0; flushControl = 0; BranchTaken = 0; JumpTaken = 0;
      BranchTarget = 0; JumpTarget = 0; CounterClear = 0; InstrIn = 0;
      model_reset();
      #2;
      check_all("reset");
      @(negedge Clk);
      Rst = 1'b1;

      // Sequential fetch 0,4,8,C then reaches 0x10
      for (int i = 0; i < 4; i++) run_step("seq");
      check("pc_at_10", PCOut, 32'h10);

      // Three-cycle stall at 0x10, then resume
      for (int i = 0; i < 3; i++) stall_step("stall3");
      check("stall3_count", 32'(StallCount), 32'd3);
      run_step("resume");
      check("resume_pc", PCOut, 32'h14);

      // Branch plus flush in the same cycle
      step("br_flush", 1, 1, 1, 1, 32'h40, 0, 0, 0);
      check("br_flush_valid", 32'(ValidOut), 32'd0);

      // Jump beats branch; same with PCWrite=0 holds
      step("jmp_vs_br", 1, 1, 0, 1, 32'h40, 1, 32'h80, 0);
      check("jmp_wins", PCOut, 32'h80);
      step("jmp_vs_br_hold", 0, 1, 0, 1, 32'h40, 1, 32'hC0, 0);
      check("redirect_ignored", PCOut, 32'h80);

      // Misaligned target is forced word-aligned
      step("br_43", 1, 1, 0, 1, 32'h43, 0, 0, 0);
      check("br_aligned", PCOut, 32'h40);

      // Stall timeout: 4-cycle run sets it, sticky, clear drops it
      step("clr0", 1, 1, 0, 0, 0, 0, 0, 1);
      for (int i = 0; i < 3; i++) stall_step("to_run");
      check("to_not_yet", 32'(StallTimeout), 32'd0);
      stall_step("to_run4");
      check("to_set", 32'(StallTimeout), 32'd1);
      run_step("to_after"); run_step("to_after");
      check("to_sticky", 32'(StallTimeout), 32'd1);
      step("clr1", 1, 1, 0, 0, 0, 0, 0, 1);
      check("to_cleared", 32'(StallTimeout), 32'd0);
      for (int i = 0; i < 3; i++) stall_step("split_a");
      run_step("split_gap");
      for (int i = 0; i < 3; i++) stall_step("split_b");
      check("to_split_runs", 32'(StallTimeout), 32'd0);
      run_step("split_end");

      // PC wraps at 2^32
      step("jmp_top", 1, 1, 0, 0, 0, 1, 32'hFFFF_FFFC, 0);
      run_step("wrap");
      check("pc_wrap", PCOut, 32'h0);

      // Stall counter saturates
      for (int i = 0; i < 20; i++) stall_step("sat");
      check("stall_sat", 32'(StallCount), 32'd15);

      // Reset mid-stall acts without a clock edge
      stall_step("pre_rst");
      #2;
      Rst = 1'b0;
      #1;
      model_reset();
      check_all("async_rst");
      @(negedge Clk);
      Rst = 1'b1;
      run_step("post_rst");
      check("post_rst_valid", 32'(ValidOut), 32'd1);

      // Random traffic
      for (int i = 0; i < 400; i++) begin
         step("rand",
              ($urandom_range(0, 3) != 0), ($urandom_range(0, 3) != 0),
              ($urandom_range(0, 7) == 0), ($urandom_range(0, 3) == 0), $urandom(),
              ($urandom_range(0, 7) == 0), $urandom(), ($urandom_range(0, 31) == 0));
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
